// File: rtl/mem_bus_arbiter_if.sv
// Request/response signal bundle between the CPU-side requesters, the arbiter and the bus bridge.
// The slave modport is the arbiter's view; the master modport is the environment's view.
`timescale 1ns/1ps
interface mem_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic [31:0] bus_rdata;
  logic        bus_data_ok;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_rdata, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_rdata, data_data_ok,
    output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_rdata, bus_data_ok
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_rdata, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_rdata, data_data_ok,
    input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
    output bus_addr_ok, bus_rdata, bus_data_ok
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / data) arbiter onto one in-order SRAM-like bus with response routing.
// Optional macro ARB_PERFCNT_EN enables the arbitration-conflict performance counter.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_WAIT        = 7
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus_if,
  output logic [31:0]        perfcnt_arb_conflict
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  lock_state_e                state_q, state_d;
  logic                       lock_gnt_q, lock_gnt_d;
  logic [7:0]                 wait_q, wait_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic lock_valid;
  logic gnt;
  logic gnt_req;
  logic fifo_full;
  logic fifo_empty;
  logic issue_req;
  logic accept;
  logic resp;
  logic head;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= MAX_WAIT_C) ? MAX_WAIT_C : v + 8'd1;
  endfunction

  // Grant: a held lock wins; otherwise data, unless fetch has starved for MAX_WAIT cycles.
  always_comb begin
    gnt = 1'b0;
    if (lock_valid)
      gnt = lock_gnt_q;
    else if (bus_if.data_req && !(bus_if.inst_req && (wait_q == MAX_WAIT_C)))
      gnt = 1'b1;
    gnt_req    = gnt ? bus_if.data_req : bus_if.inst_req;
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);
    issue_req  = gnt_req && !fifo_full && !reset;
    accept     = issue_req && bus_if.bus_addr_ok;
    resp       = bus_if.bus_data_ok && !fifo_empty && !reset;
    head       = fifo_q[rd_ptr_q];
  end

  assign bus_if.bus_req      = issue_req;
  assign bus_if.bus_wr       = gnt ? bus_if.data_wr    : 1'b0;
  assign bus_if.bus_size     = gnt ? bus_if.data_size  : 2'd2;
  assign bus_if.bus_addr     = gnt ? bus_if.data_addr  : bus_if.inst_addr;
  assign bus_if.bus_wdata    = gnt ? bus_if.data_wdata : 32'd0;
  assign bus_if.inst_addr_ok = accept && !gnt;
  assign bus_if.data_addr_ok = accept && gnt;
  // A response always belongs to the oldest outstanding entry, never one pushed this cycle.
  assign bus_if.inst_data_ok = resp && !head;
  assign bus_if.data_data_ok = resp && head;
  assign bus_if.inst_rdata   = bus_if.bus_rdata;
  assign bus_if.data_rdata   = bus_if.bus_rdata;

  always_comb begin
    state_d    = state_q;
    lock_gnt_d = lock_gnt_q;
    case (state_q)
      UNLOCKED: begin
        if (issue_req && !bus_if.bus_addr_ok) begin
          state_d    = LOCKED;
          lock_gnt_d = gnt;
        end
      end
      LOCKED: begin
        if (bus_if.bus_addr_ok || !gnt_req)
          state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_comb begin
    lock_valid = (state_q == LOCKED);
  end

  always_comb begin
    wait_d = wait_q;
    if (bus_if.inst_addr_ok)
      wait_d = 8'd0;
    else if (bus_if.inst_req)
      wait_d = sat_inc(wait_q);
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      fifo_d[wr_ptr_q] = gnt;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (resp)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({accept, resp})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lock_gnt_q <= 1'b0;
      wait_q     <= 8'd0;
      fifo_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_gnt_q <= lock_gnt_d;
      wait_q     <= wait_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

`ifdef ARB_PERFCNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (bus_if.inst_req && bus_if.data_req && !lock_valid)
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      perf_q <= 32'd0;
    else
      perf_q <= perf_d;
  end

  assign perfcnt_arb_conflict = perf_q;
`else
  assign perfcnt_arb_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grant/starvation, lock, order FIFO, reset and perf counter.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] perfcnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if ifc();

  mem_bus_arbiter #(.MAX_OUTSTANDING(4), .MAX_WAIT(7)) dut (
    .clk                  (clk),
    .reset                (reset),
    .bus_if               (ifc),
    .perfcnt_arb_conflict (perfcnt)
  );

`ifdef ARB_PERFCNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifc.inst_req    = 1'b0;
    ifc.inst_addr   = 32'd0;
    ifc.data_req    = 1'b0;
    ifc.data_wr     = 1'b0;
    ifc.data_size   = 2'd0;
    ifc.data_addr   = 32'd0;
    ifc.data_wdata  = 32'd0;
    ifc.bus_addr_ok = 1'b0;
    ifc.bus_rdata   = 32'd0;
    ifc.bus_data_ok = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic exp_inst, input logic exp_data);
    chk({tag, "_inst_data_ok"}, 32'(ifc.inst_data_ok), 32'(exp_inst));
    chk({tag, "_data_data_ok"}, 32'(ifc.data_data_ok), 32'(exp_data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic exp_d;
    // Reset state, with requests and bus handshakes driven to show the gating.
    idle();
    reset = 1'b1;
    ifc.inst_req = 1'b1; ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1;
    @(negedge clk); #1;
    chk("rst_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("rst_inst_addr_ok", 32'(ifc.inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(ifc.data_addr_ok), 32'd0);
    check_resp("rst", 1'b0, 1'b0);
    chk("rst_perf", perfcnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle();

    // 1: data only, accepted immediately, answered next cycle.
    @(negedge clk);
    ifc.data_req = 1'b1; ifc.data_wr = 1'b1; ifc.data_size = 2'd1;
    ifc.data_addr = 32'h0000_0100; ifc.data_wdata = 32'h0000_00AA; ifc.bus_addr_ok = 1'b1;
    #1;
    chk("t1_bus_req", 32'(ifc.bus_req), 32'd1);
    chk("t1_data_addr_ok", 32'(ifc.data_addr_ok), 32'd1);
    chk("t1_inst_addr_ok", 32'(ifc.inst_addr_ok), 32'd0);
    chk("t1_bus_addr", ifc.bus_addr, 32'h0000_0100);
    chk("t1_bus_wr", 32'(ifc.bus_wr), 32'd1);
    chk("t1_bus_size", 32'(ifc.bus_size), 32'd1);
    chk("t1_bus_wdata", ifc.bus_wdata, 32'h0000_00AA);
    @(negedge clk);
    idle();
    ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h0000_1234;
    #1;
    check_resp("t1_resp", 1'b0, 1'b1);
    chk("t1_data_rdata", ifc.data_rdata, 32'h0000_1234);
    chk("t1_bus_req_idle", 32'(ifc.bus_req), 32'd0);
    @(negedge clk);
    idle();

    // 2: both requesting; data wins 7 times, fetch once, then data again.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ifc.inst_req = 1'b1; ifc.inst_addr = 32'h0000_1000 + k;
      ifc.data_req = 1'b1; ifc.data_addr = 32'h0000_2000 + k; ifc.data_size = 2'd2;
      ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = k;
      #1;
      exp_d = (k != 8);
      chk($sformatf("t2_data_addr_ok_%0d", k), 32'(ifc.data_addr_ok), 32'(exp_d));
      chk($sformatf("t2_inst_addr_ok_%0d", k), 32'(ifc.inst_addr_ok), 32'(!exp_d));
      chk($sformatf("t2_bus_addr_%0d", k), ifc.bus_addr,
          exp_d ? 32'h0000_2000 + k : 32'h0000_1000 + k);
      if (k == 1)      check_resp("t2_empty", 1'b0, 1'b0);
      else if (k == 9) check_resp("t2_resp9", 1'b1, 1'b0);
      else             check_resp($sformatf("t2_resp%0d", k), 1'b0, 1'b1);
    end
    @(negedge clk);
    idle();
    ifc.bus_data_ok = 1'b1;
    #1;
    check_resp("t2_drain", 1'b0, 1'b1);
    chk("t2_perf", perfcnt, PERF_ON ? 32'd9 : 32'd0);
    @(negedge clk);
    idle();

    // 3: fetch stalled three cycles holds the bus; data arrives meanwhile.
    @(negedge clk);
    ifc.inst_req = 1'b1; ifc.inst_addr = 32'h0000_0200;
    #1;
    chk("t3_a_bus_req", 32'(ifc.bus_req), 32'd1);
    chk("t3_a_bus_addr", ifc.bus_addr, 32'h0000_0200);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      ifc.data_req = 1'b1; ifc.data_addr = 32'h0000_0300; ifc.data_wr = 1'b1; ifc.data_size = 2'd0;
      #1;
      chk($sformatf("t3_lock_addr_%0d", c), ifc.bus_addr, 32'h0000_0200);
      chk($sformatf("t3_lock_data_ok_%0d", c), 32'(ifc.data_addr_ok), 32'd0);
      chk($sformatf("t3_lock_wr_%0d", c), 32'(ifc.bus_wr), 32'd0);
      chk($sformatf("t3_lock_size_%0d", c), 32'(ifc.bus_size), 32'd2);
    end
    @(negedge clk);
    ifc.bus_addr_ok = 1'b1;
    #1;
    chk("t3_accept_inst", 32'(ifc.inst_addr_ok), 32'd1);
    chk("t3_accept_data", 32'(ifc.data_addr_ok), 32'd0);
    chk("t3_accept_addr", ifc.bus_addr, 32'h0000_0200);
    @(negedge clk);
    ifc.inst_req = 1'b0; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h0000_0055;
    #1;
    chk("t3_e_data_addr_ok", 32'(ifc.data_addr_ok), 32'd1);
    check_resp("t3_e_same_cycle", 1'b1, 1'b0);
    chk("t3_e_inst_rdata", ifc.inst_rdata, 32'h0000_0055);
    @(negedge clk);
    idle();
    ifc.bus_data_ok = 1'b1;
    #1;
    check_resp("t3_f", 1'b0, 1'b1);
    @(negedge clk);
    idle();

    // 4: fill the order FIFO with inst,data,inst,data, then drain it.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle();
      ifc.bus_addr_ok = 1'b1;
      if (k[0]) ifc.data_req = 1'b1; else ifc.inst_req = 1'b1;
      #1;
      chk($sformatf("t4_issue_%0d", k), 32'({ifc.data_addr_ok, ifc.inst_addr_ok}),
          k[0] ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    idle();
    ifc.data_req = 1'b1; ifc.bus_addr_ok = 1'b1;
    #1;
    chk("t4_full_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("t4_full_addr_ok", 32'(ifc.data_addr_ok), 32'd0);
    @(negedge clk);
    ifc.bus_data_ok = 1'b1;
    #1;
    chk("t4_full_pop_bus_req", 32'(ifc.bus_req), 32'd0);
    check_resp("t4_r0", 1'b1, 1'b0);
    @(negedge clk);
    idle();
    ifc.bus_data_ok = 1'b1;
    #1;
    check_resp("t4_r1", 1'b0, 1'b1);
    @(negedge clk); #1;
    check_resp("t4_r2", 1'b1, 1'b0);
    @(negedge clk); #1;
    check_resp("t4_r3", 1'b0, 1'b1);
    @(negedge clk); #1;
    check_resp("t4_empty_pop", 1'b0, 1'b0);
    @(negedge clk);
    idle();

    // 5: reset with two transactions outstanding.
    @(negedge clk);
    ifc.inst_req = 1'b1; ifc.bus_addr_ok = 1'b1;
    @(negedge clk);
    idle();
    ifc.data_req = 1'b1; ifc.bus_addr_ok = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    ifc.inst_req = 1'b1; ifc.data_req = 1'b1; ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1;
    #1;
    chk("t5_rst_bus_req", 32'(ifc.bus_req), 32'd0);
    chk("t5_rst_addr_ok", 32'({ifc.inst_addr_ok, ifc.data_addr_ok}), 32'd0);
    check_resp("t5_rst", 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    ifc.bus_data_ok = 1'b1;
    #1;
    check_resp("t5_after", 1'b0, 1'b0);
    @(negedge clk);
    idle();

    // 6: five unlocked cycles of simultaneous requests.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ifc.inst_req = 1'b1; ifc.data_req = 1'b1; ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1;
    end
    @(negedge clk);
    idle();
    #1;
    chk("t6_perf", perfcnt, PERF_ON ? 32'd5 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
